// File: rtl/dot_accel_mmio_pkg.sv
// Shared definitions for the dot-product accelerator: address regions,
// register selects, CTRL bit positions and FSM state encoding.
package dot_accel_mmio_pkg;

  localparam int D_WIDTH   = 64;
  localparam int A_WIDTH   = 10;
  localparam int DEPTH     = 64;
  localparam int IDX_WIDTH = 6;

  // DEPTH expressed in the width of the LEN register, for clamping/compares.
  localparam logic [IDX_WIDTH:0] DEPTH_W = (IDX_WIDTH+1)'(DEPTH);

  // Region decoded from addr[9:8].
  typedef enum logic [1:0] {
    RGN_NONE  = 2'b00,
    RGN_REG   = 2'b01,
    RGN_BUF_A = 2'b10,
    RGN_BUF_B = 2'b11
  } region_e;

  // Register select decoded from addr[4:2] inside the register region.
  typedef enum logic [2:0] {
    SEL_CTRL   = 3'd0,
    SEL_STATUS = 3'd1,
    SEL_LEN    = 3'd2,
    SEL_RESULT = 3'd3,
    SEL_CYCLES = 3'd4
  } reg_sel_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dot_accel_mmio_if.sv
// Data-memory port between the CPU MEM stage (master) and the accelerator (slave).
interface dot_accel_mmio_if;
  import dot_accel_mmio_pkg::*;

  logic [A_WIDTH-1:0] addr;
  logic [D_WIDTH-1:0] wdata;
  logic               we;
  logic [D_WIDTH-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/dot_accel_buf.sv
// Single-port synchronous RAM, one-cycle read latency, used for operand buffers.
module dot_accel_buf
  import dot_accel_mmio_pkg::*;
#(
  parameter int BUF_DEPTH = DEPTH,
  parameter int BUF_WIDTH = D_WIDTH,
  parameter int BUF_IDX   = IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [BUF_IDX-1:0]   addr,
  input  logic [BUF_WIDTH-1:0] wdata,
  output logic [BUF_WIDTH-1:0] rdata
);

  logic [BUF_WIDTH-1:0] mem [BUF_DEPTH];

  // Write-first-free RAM: write on strobe, registered read every cycle.
  // NOTE: the array has no reset; contents are undefined until written, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dot_accel_mmio.sv
// Memory-mapped dot-product accelerator: address decode, register bank,
// run-control FSM, two-stage MAC pipeline and registered load data.
module dot_accel_mmio
  import dot_accel_mmio_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  dot_accel_mmio_if.slave bus,
  output logic           busy,
  output logic           done_irq
);

  // ---------------- address decode ----------------
  region_e              region;
  reg_sel_e             sel;
  logic [IDX_WIDTH-1:0] cpu_idx;
  logic                 idx_ok;
  logic                 reg_wr;
  logic                 start_wr;
  logic                 clear_wr;
  logic                 unused_addr;

  assign region      = region_e'(bus.addr[9:8]);
  assign sel         = reg_sel_e'(bus.addr[4:2]);
  assign cpu_idx     = bus.addr[7:2];
  assign idx_ok      = {1'b0, cpu_idx} < DEPTH_W;
  assign reg_wr      = bus.we && (region == RGN_REG);
  assign start_wr    = reg_wr && (sel == SEL_CTRL) && bus.wdata[CTRL_START];
  assign clear_wr    = reg_wr && (sel == SEL_CTRL) && bus.wdata[CTRL_CLEAR];
  assign unused_addr = &{1'b0, bus.addr[1:0]};

  // ---------------- state ----------------
  state_e               state_q, state_d;
  logic [IDX_WIDTH:0]   len_q;
  logic [IDX_WIDTH:0]   run_len_q;
  logic [IDX_WIDTH:0]   idx_q;
  logic                 pipe_v_q;
  logic [D_WIDTH-1:0]   acc_q;
  logic [D_WIDTH-1:0]   result_q;
  logic [D_WIDTH-1:0]   cycles_q;
  logic                 done_irq_q;

  logic launch, issue, finish, abort;
  logic in_run;
  logic done_flag;

  assign in_run    = (state_q == ST_RUN);
  assign done_flag = (state_q == ST_DONE);
  assign busy      = in_run;
  assign done_irq  = done_irq_q;

  // State register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and run-control strobes.
  // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_wr) begin
          // START beats CLEAR in the same write; LEN==0 completes immediately.
          launch  = 1'b1;
          state_d = (len_q == '0) ? ST_DONE : ST_RUN;
        end else if (clear_wr) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (clear_wr) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          issue = (idx_q < run_len_q);
          // Finish once all reads are issued and the last product has been accumulated.
          if (!issue && !pipe_v_q) begin
            finish  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- operand buffers ----------------
  logic [IDX_WIDTH-1:0] buf_addr;
  logic                 we_a, we_b;
  logic [D_WIDTH-1:0]   q_a, q_b;
  logic [D_WIDTH-1:0]   prod;

  assign buf_addr = in_run ? idx_q[IDX_WIDTH-1:0] : cpu_idx;
  assign we_a     = !in_run && bus.we && (region == RGN_BUF_A) && idx_ok;
  assign we_b     = !in_run && bus.we && (region == RGN_BUF_B) && idx_ok;
  assign prod     = q_a * q_b;

  dot_accel_buf u_buf_a (
    .clk   (clk),
    .we    (we_a),
    .addr  (buf_addr),
    .wdata (bus.wdata),
    .rdata (q_a)
  );

  dot_accel_buf u_buf_b (
    .clk   (clk),
    .we    (we_b),
    .addr  (buf_addr),
    .wdata (bus.wdata),
    .rdata (q_b)
  );

  // Engine datapath and register bank: issue counter, MAC, result/cycle counters, LEN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q      <= '0;
      run_len_q  <= '0;
      idx_q      <= '0;
      pipe_v_q   <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      cycles_q   <= '0;
      done_irq_q <= 1'b0;
    end else begin
      done_irq_q <= 1'b0;
      if (launch) begin
        acc_q     <= '0;
        idx_q     <= '0;
        cycles_q  <= '0;
        pipe_v_q  <= 1'b0;
        run_len_q <= (len_q > DEPTH_W) ? DEPTH_W : len_q;
        if (len_q == '0) begin
          result_q   <= '0;
          done_irq_q <= 1'b1;
        end
      end else if (in_run) begin
        // Stage 1 valid: a buffer read was issued this edge; stage 2 consumes it next edge.
        pipe_v_q <= issue;
        if (issue) begin
          idx_q <= idx_q + 1'b1;
          if (cycles_q != '1) begin
            cycles_q <= cycles_q + 1'b1;
          end
        end
        if (pipe_v_q && !abort) begin
          acc_q <= acc_q + prod;
        end
        if (finish) begin
          result_q   <= acc_q;
          done_irq_q <= 1'b1;
        end
      end
      if (reg_wr && (sel == SEL_LEN) && !in_run) begin
        len_q <= bus.wdata[IDX_WIDTH:0];
      end
    end
  end

  // ---------------- load path ----------------
  logic [D_WIDTH-1:0] reg_rdata;
  logic [D_WIDTH-1:0] reg_rdata_q;
  region_e            buf_sel_q;

  // Register-bank read mux for the address presented this cycle.
  always_comb begin
    reg_rdata = '0;
    case (sel)
      SEL_STATUS: reg_rdata = {{(D_WIDTH-2){1'b0}}, done_flag, busy};
      SEL_LEN:    reg_rdata = D_WIDTH'(len_q);
      SEL_RESULT: reg_rdata = result_q;
      SEL_CYCLES: reg_rdata = cycles_q;
      default:    reg_rdata = '0;
    endcase
  end

  // Register the read source alongside the synchronous RAM read so both line up next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_rdata_q <= '0;
      buf_sel_q   <= RGN_NONE;
    end else begin
      reg_rdata_q <= (region == RGN_REG) ? reg_rdata : '0;
      if ((region == RGN_BUF_A || region == RGN_BUF_B) && idx_ok && !in_run) begin
        buf_sel_q <= region;
      end else begin
        buf_sel_q <= RGN_NONE;
      end
    end
  end

  assign bus.rdata = (buf_sel_q == RGN_BUF_A) ? q_a :
                     (buf_sel_q == RGN_BUF_B) ? q_b : reg_rdata_q;

endmodule

// File: tb/tb_dot_accel_mmio.sv
// Directed self-checking bench for dot_accel_mmio.
module tb_dot_accel_mmio;
  import dot_accel_mmio_pkg::*;

  localparam logic [9:0] A_CTRL   = 10'h100;
  localparam logic [9:0] A_STATUS = 10'h104;
  localparam logic [9:0] A_LEN    = 10'h108;
  localparam logic [9:0] A_RESULT = 10'h10C;
  localparam logic [9:0] A_CYCLES = 10'h110;
  localparam logic [9:0] A_BUFA   = 10'h200;
  localparam logic [9:0] A_BUFB   = 10'h300;

  logic clk;
  logic reset_n;
  logic busy;
  logic done_irq;
  int   checks   = 0;
  int   failures = 0;

  dot_accel_mmio_if bus ();

  dot_accel_mmio dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .done_irq (done_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [9:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, output logic [63:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.we   = 1'b0;
    @(negedge clk);
    d = bus.rdata;
  endtask

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done_irq !== 1'b1 && n < max_cycles);
  endtask

  initial begin
    logic [63:0] d;
    int          n;

    reset_n   = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_irq", 64'(done_irq), 64'd0);
    check("reset_rdata", bus.rdata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    load(A_STATUS, d); check("reset_status", d, 64'd0);
    load(A_RESULT, d); check("reset_result", d, 64'd0);

    // 1: A={1,2,3}, B={4,5,6}, LEN=3 -> 32 after exactly 5 cycles.
    store(A_BUFA + 10'h0, 64'd1); store(A_BUFA + 10'h4, 64'd2); store(A_BUFA + 10'h8, 64'd3);
    store(A_BUFB + 10'h0, 64'd4); store(A_BUFB + 10'h4, 64'd5); store(A_BUFB + 10'h8, 64'd6);
    load(A_BUFB + 10'h4, d); check("bufb1_readback", d, 64'd5);
    store(A_LEN, 64'd3);
    store(A_CTRL, 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_irq_cycle%0d", k), 64'(done_irq), (k == 5) ? 64'd1 : 64'd0);
    end
    load(A_STATUS, d); check("t1_status", d, 64'd2);

    // 6: back-to-back loads, each valid exactly one cycle after its address.
    @(negedge clk); bus.addr = A_LEN;
    @(negedge clk); check("t6_len", bus.rdata, 64'd3);    bus.addr = A_RESULT;
    @(negedge clk); check("t6_result", bus.rdata, 64'd32); bus.addr = A_CYCLES;
    @(negedge clk); check("t6_cycles", bus.rdata, 64'd3);

    // 2: wrap-around product and two-term sum.
    store(A_BUFA, 64'hFFFF_FFFF_FFFF_FFFF);
    store(A_BUFB, 64'hFFFF_FFFF_FFFF_FFFF);
    store(A_LEN, 64'd1);
    store(A_CTRL, 64'd1);
    wait_done(20, n); check("t2a_latency", 64'(n), 64'd3);
    load(A_RESULT, d); check("t2a_result", d, 64'd1);
    store(A_BUFA + 10'h4, 64'd1);
    store(A_BUFB + 10'h4, 64'd1);
    store(A_LEN, 64'd2);
    store(A_CTRL, 64'd1);
    wait_done(20, n); check("t2b_latency", 64'(n), 64'd4);
    load(A_RESULT, d); check("t2b_result", d, 64'd2);

    // 4: mid-run store/load of the buffer, LEN write ignored, then CLEAR aborts.
    store(A_LEN, 64'd60);
    store(A_CTRL, 64'd1);
    check("t4_busy", 64'(busy), 64'd1);
    store(A_BUFA, 64'h55);
    store(A_LEN, 64'd7);
    load(A_BUFA, d); check("t4_run_load", d, 64'd0);
    load(A_LEN, d); check("t4_len_kept", d, 64'd60);
    store(A_CTRL, 64'd2);
    check("t4_clear_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("t4_clear_irq", 64'(done_irq), 64'd0);
    load(A_STATUS, d); check("t4_status", d, 64'd0);
    load(A_RESULT, d); check("t4_result_kept", d, 64'd2);
    load(A_BUFA, d); check("t4_store_ignored", d, 64'hFFFF_FFFF_FFFF_FFFF);

    // 5: reset mid-run.
    store(A_CTRL, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_irq", 64'(done_irq), 64'd0);
    check("t5_rdata", bus.rdata, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    load(A_STATUS, d); check("t5_status", d, 64'd0);
    load(A_LEN, d); check("t5_len", d, 64'd0);
    load(A_RESULT, d); check("t5_result", d, 64'd0);
    load(A_CYCLES, d); check("t5_cycles", d, 64'd0);
    store(10'h004, 64'hDEAD);
    load(10'h004, d); check("t5_region0", d, 64'd0);
    load(A_CTRL, d); check("t5_ctrl_read", d, 64'd0);

    // 3: START with LEN=0 -> done immediately, single pulse.
    store(A_CTRL, 64'd1);
    check("t3_irq_on", 64'(done_irq), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("t3_irq_off", 64'(done_irq), 64'd0);
    load(A_STATUS, d); check("t3_status", d, 64'd2);
    load(A_RESULT, d); check("t3_result", d, 64'd0);

    // LEN above DEPTH clamps to DEPTH at START; START+CLEAR together starts a run.
    store(A_LEN, 64'd127);
    load(A_LEN, d); check("clamp_len_reg", d, 64'd127);
    store(A_CTRL, 64'd3);
    check("clamp_busy", 64'(busy), 64'd1);
    wait_done(100, n); check("clamp_latency", 64'(n), 64'd66);
    load(A_CYCLES, d); check("clamp_cycles", d, 64'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
